// File: rtl/RAM_shared_pkg.sv
// RAM_shared_pkg: widths shared between the single-port RAM and its SPI front end.
package RAM_shared_pkg;
   localparam int ADDR_SIZE = 8;
endpackage

// File: rtl/spi_shared_pkg.sv
// spi_shared_pkg: SPI slave FSM states and the two-bit command codes.
package spi_shared_pkg;
   typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} spi_state_e;
   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;
endpackage

// File: rtl/spi_miso_serializer.sv
// spi_miso_serializer: loads a read byte and shifts it out MSB first, flagging the last bit.
module spi_miso_serializer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clr,
   input  logic         i_load,
   input  logic [W-1:0] i_data,
   output logic         o_miso,
   output logic         o_done
);
   localparam int BW = $clog2(W + 1);
   logic [W-1:0]  r_sh;
   logic [BW-1:0] r_bits;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_sh   <= '0;
         r_bits <= '0;
      end else if (i_clr) begin
         r_bits <= '0;
      end else if (i_load) begin
         r_sh   <= i_data;
         r_bits <= BW'(W);
      end else if (r_bits != '0) begin
         r_sh   <= r_sh << 1;
         r_bits <= r_bits - 1'b1;
      end
   assign o_miso = r_bits != '0 && r_sh[W-1];
   assign o_done = !i_clr && r_bits == BW'(1);
endmodule

// File: rtl/spi_slave_fsm.sv
// spi_slave_fsm: SPI slave front end; MOSI -> rx_data command words, RAM tx_data -> MISO.
// Define SPI_RD_TIMEOUT_EN to add the rd_timeout port and a bounded wait for tx_valid.
module spi_slave_fsm
   import spi_shared_pkg::*;
#(
   parameter int ADDR_SIZE = RAM_shared_pkg::ADDR_SIZE
`ifdef SPI_RD_TIMEOUT_EN
   , parameter int RD_TIMEOUT = 16
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 SS_n,
   input  logic                 MOSI,
   output logic                 MISO,
   output logic [ADDR_SIZE+1:0] rx_data,
   output logic                 rx_valid,
   input  logic [ADDR_SIZE-1:0] tx_data,
   input  logic                 tx_valid
`ifdef SPI_RD_TIMEOUT_EN
   , output logic               rd_timeout
`endif
);
   localparam int FULL = ADDR_SIZE + 1;
   localparam int CW   = $clog2(FULL + 1);
   spi_state_e           r_state, w_next;
   logic [ADDR_SIZE:0]   r_shift;
   logic [CW-1:0]        r_cnt;
   logic                 r_rd_addr_seen, r_served;
   logic                 w_shifting, w_last, w_wait, w_timeout, w_load, w_done;
   logic [ADDR_SIZE-1:0] w_tx;

   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= IDLE;
      else r_state <= w_next;

   always_comb begin
      w_next = r_state;
      if (SS_n) w_next = IDLE;
      else if (r_state == IDLE) w_next = CHK_CMD;
      else if (r_state == CHK_CMD) w_next = !MOSI ? WRITE : r_rd_addr_seen ? READ_DATA : READ_ADD;
      w_shifting = !SS_n && r_state inside {WRITE, READ_ADD, READ_DATA} && r_cnt != CW'(FULL);
      w_last     = w_shifting && r_cnt == CW'(FULL - 1);
      w_wait     = !SS_n && r_state == READ_DATA && r_cnt == CW'(FULL) && !r_served;
   end

`ifdef SPI_RD_TIMEOUT_EN
   localparam int TW = $clog2(RD_TIMEOUT + 1);
   logic [TW-1:0] r_to_cnt;
   assign w_timeout = w_wait && !tx_valid && r_to_cnt == TW'(RD_TIMEOUT - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_to_cnt   <= '0;
         rd_timeout <= 1'b0;
      end else begin
         r_to_cnt   <= w_wait ? r_to_cnt + 1'b1 : '0;
         rd_timeout <= w_timeout;
      end
`else
   assign w_timeout = 1'b0;
`endif

   // a timed-out read is served with zeros so the master still clocks a full byte
   assign w_load = w_wait && (tx_valid || w_timeout);
   assign w_tx   = w_timeout ? '0 : tx_data;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_shift        <= '0;
         r_cnt          <= '0;
         rx_data        <= '0;
         rx_valid       <= 1'b0;
         r_rd_addr_seen <= 1'b0;
         r_served       <= 1'b0;
      end else begin
         rx_valid <= w_last;
         if (w_last) rx_data <= {r_shift, MOSI};
         if (SS_n) r_cnt <= '0;
         else if (r_state == CHK_CMD) begin
            r_shift <= {{ADDR_SIZE{1'b0}}, MOSI};
            r_cnt   <= '0;
         end else if (w_shifting) begin
            r_shift <= {r_shift[ADDR_SIZE-1:0], MOSI};
            r_cnt   <= r_cnt + 1'b1;
         end
         if (w_last && r_state == READ_ADD) r_rd_addr_seen <= 1'b1;
         else if (w_done) r_rd_addr_seen <= 1'b0;
         r_served <= !SS_n && (r_served || w_load);
      end

   spi_miso_serializer #(.W(ADDR_SIZE)) u_ser (
      .clk   (clk),
      .rst   (rst),
      .i_clr (SS_n),
      .i_load(w_load),
      .i_data(w_tx),
      .o_miso(MISO),
      .o_done(w_done)
   );
endmodule

// File: tb/tb_spi_slave_fsm.sv
// tb_spi_slave_fsm: randomized frames checked against a frame-level model of the SPI slave.
module tb_spi_slave_fsm;
   import spi_shared_pkg::*;
   logic       clk = 1'b0, rst, SS_n, MOSI, MISO, rx_valid, tx_valid;
   logic [9:0] rx_data;
   logic [7:0] tx_data;
`ifdef SPI_RD_TIMEOUT_EN
   logic       rd_timeout;
`endif
   int         n_chk = 0, n_fail = 0;
   bit         m_seen = 1'b0;
   logic [9:0] m_last = '0;

   spi_slave_fsm dut (
      .clk     (clk),
      .rst     (rst),
      .SS_n    (SS_n),
      .MOSI    (MOSI),
      .MISO    (MISO),
      .rx_data (rx_data),
      .rx_valid(rx_valid),
      .tx_data (tx_data),
      .tx_valid(tx_valid)
`ifdef SPI_RD_TIMEOUT_EN
      , .rd_timeout(rd_timeout)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic drive(input logic ss, input logic mosi, input logic txv, input logic [7:0] txd);
      @(negedge clk);
      SS_n = ss; MOSI = mosi; tx_valid = txv; tx_data = txd;
   endtask

   task automatic async_rst();
      #2 rst = 1'b1;
      #1;
      chk("rst_rxv", rx_valid, 0);
      chk("rst_rxd", rx_data, 0);
      chk("rst_miso", MISO, 0);
      m_seen = 1'b0;
      m_last = '0;
      @(negedge clk);
      rst = 1'b0; SS_n = 1'b1; tx_valid = 1'b0;
   endtask

   // cut: bits sent with SS_n low (10 = whole word); rst_at: 0..9 reset before that bit, 20+n after n MISO bits
   task automatic frame(input logic [9:0] w, input int cut, input int dly, input logic [7:0] txd, input int rst_at);
      bit rd = w[9] && m_seen;
      drive(1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
      for (int k = 0; k < cut; k++) begin
         if (k == rst_at) begin
            async_rst();
            return;
         end
         drive(1'b0, w[9-k], 1'($urandom), 8'($urandom));
         chk("rxv_shift", rx_valid, 0);
         chk("miso_shift", MISO, 0);
      end
      if (cut < 10) begin
         drive(1'b1, w[9-cut], 1'b0, 8'h00);
         chk("rxv_cut", rx_valid, 0);
         drive(1'b1, 1'($urandom), 1'b0, 8'h00);
         chk("rxv_cut2", rx_valid, 0);
         chk("rxd_hold", rx_data, m_last);
         return;
      end
      drive(1'b0, 1'($urandom), 1'b0, 8'($urandom));
      chk("rxv", rx_valid, 1);
      chk("rxd", rx_data, w);
      m_last = w;
      if (w[9] && !m_seen) m_seen = 1'b1;
      if (rd) begin
         for (int d = 0; d < dly; d++) begin
            drive(1'b0, 1'($urandom), 1'b0, 8'($urandom));
            chk("rxv_one", rx_valid, 0);
            chk("miso_wait", MISO, 0);
         end
         drive(1'b0, 1'($urandom), 1'b1, txd);
         chk("rxv_one", rx_valid, 0);
         chk("miso_wait", MISO, 0);
         for (int i = 7; i >= 0; i--) begin
            if (rst_at == 27 - i) begin
               async_rst();
               return;
            end
            drive(1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
            chk("miso_bit", MISO, txd[i]);
         end
         drive(1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
         chk("miso_after", MISO, 0);
         m_seen = 1'b0;
      end else begin
         for (int d = 0; d < 4; d++) begin
            drive(1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
            chk("rxv_one", rx_valid, 0);
            chk("miso_idle", MISO, 0);
         end
      end
      drive(1'b1, 1'($urandom), 1'b0, 8'h00);
      drive(1'b1, 1'($urandom), 1'b0, 8'h00);
      chk("end_rxv", rx_valid, 0);
      chk("end_miso", MISO, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
      repeat (2) @(negedge clk);
      chk("por_rxv", rx_valid, 0);
      chk("por_rxd", rx_data, 0);
      chk("por_miso", MISO, 0);
      rst = 1'b0;
      frame({CMD_WR_ADDR, 8'hA5}, 10, 0, 8'h00, -1);
      frame({CMD_WR_DATA, 8'h3C}, 10, 0, 8'h00, -1);
      frame({CMD_RD_ADDR, 8'h5A}, 10, 0, 8'h00, -1);
      frame({CMD_RD_DATA, 8'h00}, 10, 2, 8'hC3, -1);
      frame({CMD_RD_DATA, 8'hF0}, 10, 1, 8'hFF, -1);
      frame({CMD_WR_ADDR, 8'hAB}, 5, 0, 8'h00, -1);
      frame({CMD_WR_DATA, 8'hEE}, 10, 0, 8'h00, -1);
      frame({CMD_WR_DATA, 8'h55}, 9, 0, 8'h00, -1);
      frame({CMD_RD_DATA, 8'h81}, 10, 0, 8'h7E, -1);
      frame({CMD_WR_ADDR, 8'hC7}, 10, 0, 8'h00, -1);
      frame({CMD_RD_ADDR, 8'h12}, 10, 0, 8'h00, 4);
      frame({CMD_RD_ADDR, 8'h11}, 10, 0, 8'h00, -1);
      frame({CMD_RD_DATA, 8'hA0}, 10, 1, 8'h96, 23);
      frame({CMD_RD_DATA, 8'h44}, 10, 0, 8'h00, -1);
      frame({CMD_RD_DATA, 8'h45}, 10, 3, 8'h69, -1);
      for (int n = 0; n < 40; n++)
         frame(10'($urandom), $urandom_range(0, 3) == 0 ? $urandom_range(0, 9) : 10,
               $urandom_range(0, 5), 8'($urandom), -1);
`ifdef SPI_RD_TIMEOUT_EN
      if (!m_seen) frame({CMD_RD_ADDR, 8'h2C}, 10, 0, 8'h00, -1);
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      for (int k = 0; k < 10; k++) drive(1'b0, k < 2 ? 1'b1 : 1'($urandom), 1'b0, 8'h00);
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      chk("to_rxv", rx_valid, 1);
      for (int c = 0; c < 15; c++) begin
         drive(1'b0, 1'b0, 1'b0, 8'h00);
         chk("to_early", rd_timeout, 0);
      end
      drive(1'b0, 1'b0, 1'b0, 8'hFF);
      chk("to_pulse", rd_timeout, 1);
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b0, 1'($urandom), 8'hFF);
         chk("to_one", rd_timeout, 0);
         chk("to_miso", MISO, 0);
      end
      m_seen = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      frame({CMD_RD_DATA, 8'h01}, 10, 0, 8'h00, -1);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
